// File: rtl/mem_pkg.sv
// Shared RAM bus encoding and arbiter state types for the CPU, loader/DMA
// master and the instruction/data RAM.
package mem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  // Reserved encoding 2'b11 is never a request.
  function automatic logic cmd_valid(input logic [1:0] cmd);
    return (cmd == MEM_READ) || (cmd == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the RAM-side lines owned by the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic [1:0]        req0_cmd;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic [1:0]        req1_cmd;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_cmd, req0_addr, req0_wdata,
    input  req1_cmd, req1_addr, req1_wdata,
    input  mem_rdata,
    output gnt0, done0, rdata0,
    output gnt1, done1, rdata1,
    output mem_cmd, mem_addr, mem_wdata
  );

  modport master (
    output req0_cmd, req0_addr, req0_wdata,
    output req1_cmd, req1_addr, req1_wdata,
    output mem_rdata,
    input  gnt0, done0, rdata0,
    input  gnt1, done1, rdata1,
    input  mem_cmd, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector; the caller owns the
// last_grant history flop.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       any_valid
);

  // A lone requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    winner    = 1'b0;
    any_valid = 1'b0;
    case (valid)
      2'b01: begin
        winner    = 1'b0;
        any_valid = 1'b1;
      end
      2'b10: begin
        winner    = 1'b1;
        any_valid = 1'b1;
      end
      2'b11: begin
        winner    = ~last_grant;
        any_valid = 1'b1;
      end
      default: begin
        winner    = 1'b0;
        any_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM between the CPU
// (requester 0) and a secondary master (requester 1).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = mem_pkg::ADDR_W,
  parameter int DATA_W       = mem_pkg::DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be 1 or more");
  end

  arb_state_t        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_grant_r;
  logic              owner_r;
  mem_cmd_t          mem_cmd_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              gnt0_r;
  logic              gnt1_r;
  logic              done0_r;
  logic              done1_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  logic [1:0]        valid_s;
  logic              winner_s;
  logic              any_valid_s;
  mem_cmd_t          sel_cmd_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  assign valid_s = {cmd_valid(bus.req1_cmd), cmd_valid(bus.req0_cmd)};

  rr_pick2 u_pick (
    .valid      (valid_s),
    .last_grant (last_grant_r),
    .winner     (winner_s),
    .any_valid  (any_valid_s)
  );

  // Route the winning requester's command, address and write data.
  always_comb begin
    sel_cmd_s   = MEM_NONE;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (winner_s) begin
      sel_cmd_s   = mem_cmd_t'(bus.req1_cmd);
      sel_addr_s  = bus.req1_addr;
      sel_wdata_s = bus.req1_wdata;
    end else begin
      sel_cmd_s   = mem_cmd_t'(bus.req0_cmd);
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
    end
  end

  // Arbitration FSM; every output is a flop so nothing is combinational from req inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      mem_cmd_r    <= MEM_NONE;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (any_valid_s) begin
            state_r      <= BUSY;
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
            mem_cmd_r    <= sel_cmd_s;
            mem_addr_r   <= sel_addr_s;
            mem_wdata_r  <= sel_wdata_s;
            cnt_r        <= CNT_LOAD;
            gnt0_r       <= ~winner_s;
            gnt1_r       <= winner_s;
          end else begin
            mem_cmd_r <= MEM_NONE;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_r == CNT_ZERO) begin
            state_r   <= RESP;
            mem_cmd_r <= MEM_NONE;
            done0_r   <= ~owner_r;
            done1_r   <= owner_r;
            // Writes take the same slot but leave the requester's read data alone.
            if (mem_cmd_r == MEM_READ) begin
              if (owner_r) begin
                rdata1_r <= bus.mem_rdata;
              end else begin
                rdata0_r <= bus.mem_rdata;
              end
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP: begin
          state_r <= IDLE;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= CNT_ZERO;
          mem_cmd_r <= MEM_NONE;
          gnt0_r    <= 1'b0;
          gnt1_r    <= 1'b0;
          done0_r   <= 1'b0;
          done1_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_cmd   = mem_cmd_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RAM models with latency-accurate read data,
// a per-requester expected-response queue and a done-pulse monitor.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) b1 ();
  mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) b3 ();

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: read data is only correct once mem_cmd READ has been held for the latency.
  logic [15:0] mdl  [512];
  logic [15:0] ram1 [512];
  logic [15:0] ram3 [512];
  bit          ram_loaded = 1'b0;
  int          hold1 = 0;
  int          hold3 = 0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) begin
        ram1[i] <= mdl[i];
        ram3[i] <= mdl[i];
      end
      ram_loaded <= 1'b1;
    end else begin
      if (b1.mem_cmd == 2'b10) ram1[b1.mem_addr] <= b1.mem_wdata;
      if (b3.mem_cmd == 2'b10) ram3[b3.mem_addr] <= b3.mem_wdata;
    end
    hold1 <= (b1.mem_cmd == 2'b01) ? hold1 + 1 : 0;
    hold3 <= (b3.mem_cmd == 2'b01) ? hold3 + 1 : 0;
  end

  assign b1.mem_rdata = (hold1 == 0) ? ram1[b1.mem_addr] : ~ram1[b1.mem_addr];
  assign b3.mem_rdata = (hold3 == 2) ? ram3[b3.mem_addr] : ~ram3[b3.mem_addr];

  // Reference model: expected read data per requester, in issue order.
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] last_rd0;
  logic [15:0] last_rd1;
  int          done_order [$];
  int          done_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd);
    if (r == 0) begin
      b1.req0_cmd = cmd; b1.req0_addr = addr; b1.req0_wdata = wd;
    end else begin
      b1.req1_cmd = cmd; b1.req1_addr = addr; b1.req1_wdata = wd;
    end
  endtask

  task automatic expect_push(input int r, input logic [1:0] cmd, input logic [8:0] addr,
                             input logic [15:0] wd);
    logic [15:0] e;
    if (cmd == 2'b01) begin
      e = mdl[addr];
      if (r == 0) last_rd0 = e; else last_rd1 = e;
    end else if (cmd == 2'b10) begin
      mdl[addr] = wd;
      e = (r == 0) ? last_rd0 : last_rd1;
    end else begin
      return;
    end
    if (r == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_done(input int r);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (r == 0) ? b1.done0 : b1.done1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done%0d wait: got no pulse expected one within 40 cycles", r);
    end
  endtask

  task automatic issue(input int r, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd);
    expect_push(r, cmd, addr, wd);
    drive(r, cmd, addr, wd);
    wait_done(r);
    drive(r, 2'b00, addr, wd);
  endtask

  task automatic rand_seq(input int r, input int n);
    logic [8:0]  a;
    logic [15:0] d;
    int          kind;
    for (int i = 0; i < n; i++) begin
      a    = {1'(r), 8'($urandom_range(0, 255))};
      d    = 16'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        drive(r, 2'b11, a, d);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        drive(r, 2'b00, a, d);
      end else begin
        issue(r, (kind < 6) ? 2'b01 : 2'b10, a, d);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: pop and compare on every done pulse, and watch mutual exclusion.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt mutex", 32'(b1.gnt0 & b1.gnt1), 32'(0));
      chk("done mutex", 32'(b1.done0 & b1.done1), 32'(0));
      if (b1.done0) begin
        chk("done0 expected", 32'(q0.size() != 0), 32'(1));
        if (q0.size() != 0) chk("rdata0", 32'(b1.rdata0), 32'(q0.pop_front()));
        done_order.push_back(0);
        done_cyc.push_back(cyc);
      end
      if (b1.done1) begin
        chk("done1 expected", 32'(q1.size() != 0), 32'(1));
        if (q1.size() != 0) chk("rdata1", 32'(b1.rdata1), 32'(q1.pop_front()));
        done_order.push_back(1);
        done_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int first;
    reset    = 1'b1;
    last_rd0 = 16'h0000;
    last_rd1 = 16'h0000;
    drive(0, 2'b00, 9'h000, 16'h0000);
    drive(1, 2'b00, 9'h000, 16'h0000);
    b3.req0_cmd = 2'b00; b3.req0_addr = 9'h000; b3.req0_wdata = 16'h0000;
    b3.req1_cmd = 2'b00; b3.req1_addr = 9'h000; b3.req1_wdata = 16'h0000;
    for (int i = 0; i < 512; i++) mdl[i[8:0]] = 16'($urandom);
    mdl[9'h005] = 16'hBEEF;
    mdl[9'h1FF] = 16'hA5C3;

    repeat (3) @(negedge clk);
    chk("u1 reset ctl", 32'({b1.gnt0, b1.gnt1, b1.done0, b1.done1, b1.mem_cmd}), 32'(0));
    chk("u1 reset addr", 32'(b1.mem_addr), 32'(0));
    chk("u1 reset wdata", 32'(b1.mem_wdata), 32'(0));
    chk("u1 reset rdata", 32'({b1.rdata0, b1.rdata1}), 32'(0));
    chk("u3 reset ctl", 32'({b3.gnt0, b3.gnt1, b3.done0, b3.done1, b3.mem_cmd}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Tie straight after reset: requester 0 first, then the write 3 cycles later.
    expect_push(0, 2'b01, 9'h010, 16'h0000);
    expect_push(1, 2'b10, 9'h020, 16'h1234);
    drive(0, 2'b01, 9'h010, 16'h0000);
    drive(1, 2'b10, 9'h020, 16'h1234);
    @(negedge clk);
    chk("tie first cmd", 32'(b1.mem_cmd), 32'(2'b01));
    chk("tie first addr", 32'(b1.mem_addr), 32'(9'h010));
    chk("tie first gnt", 32'({b1.gnt0, b1.gnt1}), 32'(2'b10));
    @(negedge clk);
    chk("tie done0", 32'(b1.done0), 32'(1));
    drive(0, 2'b00, 9'h010, 16'h0000);
    @(negedge clk);
    chk("tie gap cmd", 32'(b1.mem_cmd), 32'(2'b00));
    @(negedge clk);
    chk("tie write cmd", 32'(b1.mem_cmd), 32'(2'b10));
    chk("tie write addr", 32'(b1.mem_addr), 32'(9'h020));
    chk("tie write data", 32'(b1.mem_wdata), 32'(16'h1234));
    chk("tie write gnt", 32'({b1.gnt0, b1.gnt1}), 32'(2'b01));
    @(negedge clk);
    chk("tie done1", 32'(b1.done1), 32'(1));
    drive(1, 2'b00, 9'h020, 16'h1234);
    @(negedge clk);
    issue(0, 2'b01, 9'h020, 16'h0000);
    @(negedge clk);

    // Single read with latency 1.
    expect_push(0, 2'b01, 9'h005, 16'h0000);
    drive(0, 2'b01, 9'h005, 16'h0000);
    @(negedge clk);
    chk("rd cmd", 32'(b1.mem_cmd), 32'(2'b01));
    chk("rd addr", 32'(b1.mem_addr), 32'(9'h005));
    @(negedge clk);
    chk("rd done0", 32'(b1.done0), 32'(1));
    chk("rd rdata0", 32'(b1.rdata0), 32'(16'hBEEF));
    chk("rd side1", 32'({b1.gnt1, b1.done1}), 32'(0));
    drive(0, 2'b00, 9'h005, 16'h0000);
    @(negedge clk);

    // Latency 3 instance.
    b3.req1_cmd = 2'b01; b3.req1_addr = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rl3 busy", 32'({b3.mem_cmd, b3.mem_addr, b3.gnt1, b3.done1}),
          32'({2'b01, 9'h1FF, 1'b1, 1'b0}));
    end
    @(negedge clk);
    chk("rl3 done", 32'({b3.done1, b3.gnt1, b3.mem_cmd}), 32'({1'b1, 1'b1, 2'b00}));
    chk("rl3 rdata1", 32'(b3.rdata1), 32'(16'hA5C3));
    b3.req1_cmd = 2'b00;
    @(negedge clk);
    chk("rl3 after", 32'({b3.done1, b3.gnt1}), 32'(0));

    // Reserved command never wins; address changes during the access are ignored.
    drive(0, 2'b11, 9'h033, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reserved idle", 32'({b1.mem_cmd, b1.gnt0}), 32'(0));
    end
    expect_push(0, 2'b01, 9'h044, 16'h0000);
    drive(0, 2'b01, 9'h044, 16'h0000);
    @(negedge clk);
    chk("latched addr busy", 32'(b1.mem_addr), 32'(9'h044));
    drive(0, 2'b01, 9'h0AA, 16'h0000);
    @(negedge clk);
    chk("latched addr resp", 32'(b1.mem_addr), 32'(9'h044));
    chk("latched done0", 32'(b1.done0), 32'(1));
    drive(0, 2'b00, 9'h0AA, 16'h0000);
    @(negedge clk);

    // Fairness: both requesters continuously reading.
    base  = done_order.size();
    first = 1 - done_order[base-1];
    fork
      for (int i = 0; i < 3; i++) issue(0, 2'b01, {1'b0, 8'($urandom_range(0, 255))}, 16'h0000);
      for (int i = 0; i < 3; i++) issue(1, 2'b01, {1'b1, 8'($urandom_range(0, 255))}, 16'h0000);
    join
    @(negedge clk);
    chk("fair count", 32'(done_order.size() - base), 32'(6));
    for (int i = 0; i < 6 && base + i < done_order.size(); i++) begin
      chk("fair order", 32'(done_order[base+i]), 32'((first + i) % 2));
      if (i > 0) chk("fair spacing", 32'(done_cyc[base+i] - done_cyc[base+i-1]), 32'(3));
    end

    // Reset in the middle of a requester 1 access: no done, and requester 0 wins next.
    drive(1, 2'b01, 9'h105, 16'h0000);
    @(negedge clk);
    chk("abort busy gnt1", 32'(b1.gnt1), 32'(1));
    reset = 1'b1;
    drive(1, 2'b00, 9'h105, 16'h0000);
    @(negedge clk);
    chk("abort ctl", 32'({b1.gnt0, b1.gnt1, b1.done0, b1.done1, b1.mem_cmd}), 32'(0));
    chk("abort rdata", 32'({b1.rdata0, b1.rdata1}), 32'(0));
    chk("abort addr", 32'(b1.mem_addr), 32'(0));
    reset    = 1'b0;
    last_rd0 = 16'h0000;
    last_rd1 = 16'h0000;
    base = done_order.size();
    expect_push(0, 2'b01, 9'h011, 16'h0000);
    expect_push(1, 2'b01, 9'h111, 16'h0000);
    drive(0, 2'b01, 9'h011, 16'h0000);
    drive(1, 2'b01, 9'h111, 16'h0000);
    fork
      begin wait_done(0); drive(0, 2'b00, 9'h011, 16'h0000); end
      begin wait_done(1); drive(1, 2'b00, 9'h111, 16'h0000); end
    join
    @(negedge clk);
    chk("post reset count", 32'(done_order.size() - base), 32'(2));
    if (done_order.size() > base) chk("post reset winner", 32'(done_order[base]), 32'(0));

    // Random traffic, each requester in its own half of memory.
    fork
      rand_seq(0, 30);
      rand_seq(1, 30);
    join
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
